// File: rtl/axi2mem_pkg.sv
// Shared constants and types for the AXI-to-memory read command path.
package axi2mem_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
  localparam int unsigned DEFAULT_ID_WIDTH   = 6;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_e;

  // Beats wider than the 64-bit bus are not supported; larger sizes behave as 8 bytes.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    logic [2:0] res;
    if (size > 3'd3) begin
      res = 3'd3;
    end else begin
      res = size;
    end
    return res;
  endfunction

endpackage

// File: rtl/axi2mem_burst_addr_next.sv
// Next beat address for an AXI burst (FIXED / INCR / WRAP), purely combinational.
module axi2mem_burst_addr_next
  import axi2mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [2:0]            i_size,
  input  logic [7:0]            i_len,
  input  logic [1:0]            i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr
);

  localparam logic [ADDR_WIDTH-1:0] L_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            w_size;
  logic [ADDR_WIDTH-1:0] w_bytes;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic [ADDR_WIDTH-1:0] w_mask;
  logic                  w_wrap_legal;

  // Address arithmetic and burst-type selection.
  always_comb begin
    w_size       = clamp_size(i_size);
    w_bytes      = L_ONE << w_size;
    w_incr       = i_addr + w_bytes;
    w_mask       = (({{(ADDR_WIDTH-8){1'b0}}, i_len} + L_ONE) << w_size) - L_ONE;
    w_wrap_legal = (i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15);
    o_next_addr  = i_addr;
    case (i_burst)
      BURST_FIXED: o_next_addr = i_addr;
      BURST_WRAP: begin
        // Illegal wrap lengths fall back to incrementing.
        if (w_wrap_legal) begin
          o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
        end else begin
          o_next_addr = w_incr;
        end
      end
      default: o_next_addr = w_incr;
    endcase
  end

endmodule

// File: rtl/axi2mem_rd_trans_gen.sv
// Splits one AXI AR burst into per-beat 32-bit word requests on two lanes
// (lane 0 low word, lane 1 high word of the 64-bit beat).
module axi2mem_rd_trans_gen
  import axi2mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned ID_WIDTH   = DEFAULT_ID_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]              ar_len_i,
  input  logic [2:0]              ar_size_i,
  input  logic [1:0]              ar_burst_i,
  input  logic [ID_WIDTH-1:0]     ar_id_i,
  output logic [1:0]              trans_rd_req_o,
  input  logic [1:0]              trans_rd_gnt_i,
  output logic [2*ADDR_WIDTH-1:0] trans_rd_add_o,
  output logic [2*ID_WIDTH-1:0]   trans_rd_id_o,
  output logic [1:0]              trans_rd_last_o,
  output logic                    busy_o
);

  rd_state_e             r_state, w_state_nxt;
  logic [7:0]            r_cnt, w_cnt_nxt;
  logic [7:0]            r_len, w_len_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [ID_WIDTH-1:0]   r_id, w_id_nxt;
  logic [2:0]            r_size, w_size_nxt;
  logic [1:0]            r_burst, w_burst_nxt;
  logic [1:0]            r_done, w_done_nxt;

  logic                  w_busy;
  logic [1:0]            w_req;
  logic [1:0]            w_acc;
  logic                  w_complete;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [ADDR_WIDTH-1:0] w_lane0_addr;

  assign w_busy       = (r_state == ST_BURST);
  assign w_req        = w_busy ? ~r_done : 2'b00;
  assign w_acc        = w_req & trans_rd_gnt_i;
  assign w_complete   = w_busy & ((r_done | w_acc) == 2'b11);
  assign w_lane0_addr = {r_addr[ADDR_WIDTH-1:3], 3'b000};

  axi2mem_burst_addr_next #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_next (
    .i_addr     (r_addr),
    .i_size     (r_size),
    .i_len      (r_len),
    .i_burst    (r_burst),
    .o_next_addr(w_next_addr)
  );

  // State and burst-context registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_len   <= 8'd0;
      r_addr  <= {ADDR_WIDTH{1'b0}};
      r_id    <= {ID_WIDTH{1'b0}};
      r_size  <= 3'd0;
      r_burst <= 2'b00;
      r_done  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_addr  <= w_addr_nxt;
      r_id    <= w_id_nxt;
      r_size  <= w_size_nxt;
      r_burst <= w_burst_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state: capture AR in IDLE, track lane completion and advance beats in BURST.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_addr_nxt  = r_addr;
    w_id_nxt    = r_id;
    w_size_nxt  = r_size;
    w_burst_nxt = r_burst;
    w_done_nxt  = r_done;
    case (r_state)
      ST_IDLE: begin
        if (ar_valid_i) begin
          w_state_nxt = ST_BURST;
          w_cnt_nxt   = ar_len_i;
          w_len_nxt   = ar_len_i;
          w_addr_nxt  = ar_addr_i;
          w_id_nxt    = ar_id_i;
          w_size_nxt  = clamp_size(ar_size_i);
          w_burst_nxt = ar_burst_i;
          w_done_nxt  = 2'b00;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (w_complete) begin
          w_done_nxt = 2'b00;
          if (r_cnt == 8'd0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt  = r_cnt - 8'd1;
            w_addr_nxt = w_next_addr;
          end
        end else begin
          // A lane granted early stays quiet until its partner is granted.
          w_done_nxt = r_done | w_acc;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so reset clears them immediately.
  always_comb begin
    ar_ready_o      = 1'b1;
    busy_o          = 1'b0;
    trans_rd_req_o  = 2'b00;
    trans_rd_add_o  = {(2*ADDR_WIDTH){1'b0}};
    trans_rd_id_o   = {(2*ID_WIDTH){1'b0}};
    trans_rd_last_o = 2'b00;
    if (w_busy) begin
      ar_ready_o      = 1'b0;
      busy_o          = 1'b1;
      trans_rd_req_o  = w_req;
      trans_rd_add_o  = {w_lane0_addr + {{(ADDR_WIDTH-3){1'b0}}, 3'b100}, w_lane0_addr};
      trans_rd_id_o   = {r_id, r_id};
      trans_rd_last_o = (r_cnt == 8'd0) ? 2'b11 : 2'b00;
    end else begin
      ar_ready_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_axi2mem_rd_trans_gen.sv
// Directed bench for axi2mem_rd_trans_gen with a beat-level reference model.
module tb_axi2mem_rd_trans_gen;

  localparam int AW = 32;
  localparam int IW = 6;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            ar_valid_i;
  logic            ar_ready_o;
  logic [AW-1:0]   ar_addr_i;
  logic [7:0]      ar_len_i;
  logic [2:0]      ar_size_i;
  logic [1:0]      ar_burst_i;
  logic [IW-1:0]   ar_id_i;
  logic [1:0]      trans_rd_req_o;
  logic [1:0]      trans_rd_gnt_i;
  logic [2*AW-1:0] trans_rd_add_o;
  logic [2*IW-1:0] trans_rd_id_o;
  logic [1:0]      trans_rd_last_o;
  logic            busy_o;

  always #5 clk = ~clk;

  axi2mem_rd_trans_gen #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .ar_valid_i     (ar_valid_i),
    .ar_ready_o     (ar_ready_o),
    .ar_addr_i      (ar_addr_i),
    .ar_len_i       (ar_len_i),
    .ar_size_i      (ar_size_i),
    .ar_burst_i     (ar_burst_i),
    .ar_id_i        (ar_id_i),
    .trans_rd_req_o (trans_rd_req_o),
    .trans_rd_gnt_i (trans_rd_gnt_i),
    .trans_rd_add_o (trans_rd_add_o),
    .trans_rd_id_o  (trans_rd_id_o),
    .trans_rd_last_o(trans_rd_last_o),
    .busy_o         (busy_o)
  );

  // Reference model: a burst is a list of beats; each lane counts its own accepted beats.
  bit          m_busy;
  int          m_cnt0, m_cnt1, m_len;
  logic [31:0] m_addr;
  logic [2:0]  m_size;
  logic [1:0]  m_burst;
  logic [5:0]  m_id;

  int checks = 0;
  int failures = 0;

  logic [31:0] log_l0[$];
  logic [31:0] log_l1[$];
  logic        log_last[$];
  int          busy_cyc;
  int          req0_cnt;

  function automatic logic [31:0] model_beat_addr(int k);
    logic [31:0] bytes, lin, mask;
    bytes = 32'd1 << m_size;
    lin   = m_addr + bytes * 32'(k);
    mask  = 32'(m_len + 1) * bytes - 32'd1;
    if (m_burst == 2'b00) return m_addr;
    if (m_burst == 2'b10 && (m_len == 1 || m_len == 3 || m_len == 7 || m_len == 15))
      return (m_addr & ~mask) | (lin & mask);
    return lin;
  endfunction

  function automatic int model_beat();
    return (m_cnt0 < m_cnt1) ? m_cnt0 : m_cnt1;
  endfunction

  function automatic logic [1:0] model_req();
    int b;
    b = model_beat();
    if (!m_busy) return 2'b00;
    return {m_cnt1 == b, m_cnt0 == b};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic compare_outputs();
    int          b;
    logic [31:0] a0;
    b = model_beat();
    chk("ar_ready", 64'(ar_ready_o), 64'(!m_busy));
    chk("busy", 64'(busy_o), 64'(m_busy));
    chk("req", 64'(trans_rd_req_o), 64'(model_req()));
    if (m_busy) begin
      a0 = model_beat_addr(b) & 32'hFFFF_FFF8;
      chk("add_lane0", 64'(trans_rd_add_o[31:0]), 64'(a0));
      chk("add_lane1", 64'(trans_rd_add_o[63:32]), 64'(a0 + 32'd4));
      chk("id_lanes", 64'(trans_rd_id_o), 64'({m_id, m_id}));
      chk("last", 64'(trans_rd_last_o), (b == m_len) ? 64'd3 : 64'd0);
    end
    if (trans_rd_req_o[0] && trans_rd_gnt_i[0]) begin
      log_l0.push_back(trans_rd_add_o[31:0]);
      log_last.push_back(trans_rd_last_o[0]);
    end
    if (trans_rd_req_o[1] && trans_rd_gnt_i[1]) log_l1.push_back(trans_rd_add_o[63:32]);
    if (busy_o) busy_cyc++;
    if (trans_rd_req_o[0]) req0_cnt++;
  endtask

  task automatic model_update();
    logic [1:0] acc;
    if (!m_busy) begin
      if (ar_valid_i) begin
        m_busy  = 1'b1;
        m_cnt0  = 0;
        m_cnt1  = 0;
        m_len   = int'(ar_len_i);
        m_addr  = ar_addr_i;
        m_size  = (ar_size_i > 3'd3) ? 3'd3 : ar_size_i;
        m_burst = ar_burst_i;
        m_id    = ar_id_i;
      end
    end else begin
      acc = model_req() & trans_rd_gnt_i;
      if (acc[0]) m_cnt0++;
      if (acc[1]) m_cnt1++;
      if (m_cnt0 == m_len + 1 && m_cnt1 == m_len + 1) m_busy = 1'b0;
    end
  endtask

  task automatic cycle(input logic [1:0] g);
    trans_rd_gnt_i = g;
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [5:0] id, input int stall);
    bit started = 1'b0;
    bit finished = 1'b0;
    int bc = 0;
    log_l0.delete(); log_l1.delete(); log_last.delete();
    busy_cyc = 0; req0_cnt = 0;
    ar_addr_i = addr; ar_len_i = len; ar_size_i = size; ar_burst_i = burst; ar_id_i = id;
    ar_valid_i = 1'b1;
    for (int n = 0; n < 80 && !finished; n++) begin
      cycle((started && bc < stall) ? 2'b01 : 2'b11);
      if (started) bc++;
      if (!started && m_busy) begin
        started = 1'b1;
        ar_valid_i = 1'b0;
      end else if (started && !m_busy) begin
        finished = 1'b1;
      end
    end
    ar_valid_i = 1'b0;
    chk("burst_done_in_budget", 64'(finished), 64'd1);
  endtask

  task automatic check_seq(input string tag, input int n, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3, input bit lane1);
    logic [31:0] e[4];
    int          sz;
    e = '{e0, e1, e2, e3};
    sz = lane1 ? log_l1.size() : log_l0.size();
    chk({tag, "_count"}, 64'(sz), 64'(n));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_beat%0d", tag, i), lane1 ? 64'(log_l1[i]) : 64'(log_l0[i]), 64'(e[i]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 64'(trans_rd_req_o), 64'd0);
    chk({tag, "_ar_ready"}, 64'(ar_ready_o), 64'd1);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_add"}, trans_rd_add_o, 64'd0);
    chk({tag, "_id"}, 64'(trans_rd_id_o), 64'd0);
    chk({tag, "_last"}, 64'(trans_rd_last_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; ar_valid_i = 1'b0; ar_addr_i = 32'd0; ar_len_i = 8'd0; ar_size_i = 3'd0;
    ar_burst_i = 2'b00; ar_id_i = 6'd0; trans_rd_gnt_i = 2'b00;
    m_busy = 1'b0; m_cnt0 = 0; m_cnt1 = 0; m_len = 0; m_addr = 32'd0; m_size = 3'd0;
    m_burst = 2'b00; m_id = 6'd0;
    #2;
    check_reset_outputs("reset");
    @(negedge clk); rst_ni = 1'b1;
    @(posedge clk); #2;

    // 1: INCR 8-byte beats, full grants
    run_burst(32'h1000, 8'd3, 3'd3, 2'b01, 6'd5, 0);
    check_seq("t1_l0", 4, 32'h1000, 32'h1008, 32'h1010, 32'h1018, 1'b0);
    check_seq("t1_l1", 4, 32'h1004, 32'h100C, 32'h1014, 32'h101C, 1'b1);
    chk("t1_last_seq", 64'({log_last[0], log_last[1], log_last[2], log_last[3]}), 64'b0001);
    chk("t1_busy_cycles", 64'(busy_cyc), 64'd4);
    #1;
    chk("t1_ready_after", 64'(ar_ready_o), 64'd1);

    // 2: WRAP across a 32-byte window
    run_burst(32'h1018, 8'd3, 3'd3, 2'b10, 6'd2, 0);
    check_seq("t2_l0", 4, 32'h1018, 32'h1000, 32'h1008, 32'h1010, 1'b0);

    // 3: lane 1 stalled for three cycles
    run_burst(32'h4000, 8'd1, 3'd3, 2'b01, 6'd7, 3);
    check_seq("t3_l0", 2, 32'h4000, 32'h4008, 32'h0, 32'h0, 1'b0);
    check_seq("t3_l1", 2, 32'h4004, 32'h400C, 32'h0, 32'h0, 1'b1);
    chk("t3_req0_cycles", 64'(req0_cnt), 64'd2);
    chk("t3_busy_cycles", 64'(busy_cyc), 64'd5);

    // 4: narrow INCR, 4-byte beats
    run_burst(32'h2004, 8'd3, 3'd2, 2'b01, 6'd1, 0);
    check_seq("t4_l0", 4, 32'h2000, 32'h2008, 32'h2008, 32'h2010, 1'b0);

    // 5: FIXED
    run_burst(32'h3008, 8'd2, 3'd3, 2'b00, 6'd3, 0);
    check_seq("t5_l0", 3, 32'h3008, 32'h3008, 32'h3008, 32'h0, 1'b0);
    check_seq("t5_l1", 3, 32'h300C, 32'h300C, 32'h300C, 32'h0, 1'b1);
    chk("t5_last_seq", 64'({log_last[0], log_last[1], log_last[2]}), 64'b001);

    // 7: oversize clamped to 8 bytes, burst code 11 as INCR
    run_burst(32'h7000, 8'd1, 3'd4, 2'b11, 6'd4, 0);
    check_seq("t7_l0", 2, 32'h7000, 32'h7008, 32'h0, 32'h0, 1'b0);

    // 6: reset mid-burst with no grants, then a single-beat burst
    ar_addr_i = 32'h5000; ar_len_i = 8'd7; ar_size_i = 3'd3; ar_burst_i = 2'b01; ar_id_i = 6'd3;
    ar_valid_i = 1'b1;
    cycle(2'b00);
    ar_valid_i = 1'b0;
    cycle(2'b00);
    cycle(2'b00);
    chk("t6_busy_before_reset", 64'(busy_o), 64'd1);
    #1 rst_ni = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    m_busy = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
    @(negedge clk); #1 rst_ni = 1'b1;
    @(posedge clk); #2;
    run_burst(32'h6010, 8'd0, 3'd3, 2'b01, 6'd9, 0);
    check_seq("t6_l0", 1, 32'h6010, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("t6_last", 64'(log_last.size() == 1 && log_last[0] == 1'b1), 64'd1);
    chk("t6_busy_cycles", 64'(busy_cyc), 64'd1);
    cycle(2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
